ddr3_cmd_issuer: RTL and testbench

//  Final command stage of the DDR3 controller; drives the DDR3 SDRAM device pins directly.
//  - Runs power-up reset/CKE sequencing.
//  - Accepts one abstract command per valid/ready handshake.
//  - Tracks open/closed state per bank (8 banks).
//  - Holds each command until its JEDEC timing window is met, then registers the pin encoding.
//  - Datapath (dq/dqs/dm/odt) belongs to the separate data-path block.

---
 rtl/ddr3_pkg.sv | 47 ++++
 rtl/ddr3_bank_timer.sv | 72 +++++++
 rtl/ddr3_cmd_issuer.sv | 190 +++++++++++++++++++
 tb/tb_ddr3_cmd_issuer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 command issuer: abstract ops, pin encodings,
// init-sequence states and default JEDEC timing values in controller clock cycles.
package ddr3_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpAct  = 3'd1,
    OpRd   = 3'd2,
    OpWr   = 3'd3,
    OpPre  = 3'd4,
    OpPrea = 3'd5,
    OpRef  = 3'd6,
    OpMrs  = 3'd7
  } op_e;

  // {csbar, rasbar, casbar, webar}
  localparam logic [3:0] PinDes = 4'b1111;
  localparam logic [3:0] PinNop = 4'b0111;
  localparam logic [3:0] PinAct = 4'b0011;
  localparam logic [3:0] PinRd  = 4'b0101;
  localparam logic [3:0] PinWr  = 4'b0100;
  localparam logic [3:0] PinPre = 4'b0010;
  localparam logic [3:0] PinRef = 4'b0001;
  localparam logic [3:0] PinMrs = 4'b0000;

  typedef enum logic [1:0] {
    StRstLow = 2'd0,
    StCkeLow = 2'd1,
    StXpr    = 2'd2,
    StRun    = 2'd3
  } init_state_e;

  localparam int unsigned NumBanks    = 8;
  localparam int unsigned TwDefault   = 10;
  localparam int unsigned TRstDefault = 200;
  localparam int unsigned TCkeDefault = 500;
  localparam int unsigned TXprDefault = 60;
  localparam int unsigned TRcdDefault = 5;
  localparam int unsigned TRpDefault  = 5;
  localparam int unsigned TRasDefault = 14;
  localparam int unsigned TWtpDefault = 14;
  localparam int unsigned TRtpDefault = 4;
  localparam int unsigned TCcdDefault = 4;
  localparam int unsigned TMrdDefault = 4;
  localparam int unsigned TRfcDefault = 59;

endpackage

// File: rtl/ddr3_bank_timer.sv
// Per-bank open/closed flag plus the three countdown timers gating ACT, column and PRE
// commands to this bank. A timer value of zero means the corresponding command may issue.
module ddr3_bank_timer
  import ddr3_pkg::*;
#(
  parameter int unsigned Tw   = TwDefault,
  parameter int unsigned TRcd = TRcdDefault,
  parameter int unsigned TRp  = TRpDefault,
  parameter int unsigned TRas = TRasDefault,
  parameter int unsigned TWtp = TWtpDefault,
  parameter int unsigned TRtp = TRtpDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic act_issue,
  input  logic pre_issue,
  input  logic rd_issue,
  input  logic wr_issue,
  output logic act_ok,
  output logic col_ok,
  output logic pre_ok,
  output logic is_open
);

  logic          open_q, open_d;
  logic [Tw-1:0] act_t_q, act_t_d;
  logic [Tw-1:0] col_t_q, col_t_d;
  logic [Tw-1:0] pre_t_q, pre_t_d;

  function automatic logic [Tw-1:0] dec(input logic [Tw-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

  always_comb begin
    open_d  = open_q;
    act_t_d = dec(act_t_q);
    col_t_d = dec(col_t_q);
    pre_t_d = dec(pre_t_q);
    if (act_issue) begin
      open_d  = 1'b1;
      col_t_d = Tw'(TRcd);
      pre_t_d = Tw'(TRas);
    end
    // Column commands only ever extend the PRE deadline, never shorten it.
    if (rd_issue && (pre_t_d < Tw'(TRtp))) pre_t_d = Tw'(TRtp);
    if (wr_issue && (pre_t_d < Tw'(TWtp))) pre_t_d = Tw'(TWtp);
    if (pre_issue) begin
      open_d  = 1'b0;
      act_t_d = Tw'(TRp);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      open_q  <= 1'b0;
      act_t_q <= '0;
      col_t_q <= '0;
      pre_t_q <= '0;
    end else begin
      open_q  <= open_d;
      act_t_q <= act_t_d;
      col_t_q <= col_t_d;
      pre_t_q <= pre_t_d;
    end
  end

  assign act_ok  = (act_t_q == '0);
  assign col_ok  = (col_t_q == '0);
  assign pre_ok  = (pre_t_q == '0);
  assign is_open = open_q;

endmodule

// File: rtl/ddr3_cmd_issuer.sv
// DDR3 command issuer: power-up sequencing, per-bank legality and timing checks, and the
// registered command/address pins. One accepted command drives the pins for one cycle.
module ddr3_cmd_issuer
  import ddr3_pkg::*;
#(
  parameter int unsigned Tw   = TwDefault,
  parameter int unsigned TRst = TRstDefault,
  parameter int unsigned TCke = TCkeDefault,
  parameter int unsigned TXpr = TXprDefault,
  parameter int unsigned TRcd = TRcdDefault,
  parameter int unsigned TRp  = TRpDefault,
  parameter int unsigned TRas = TRasDefault,
  parameter int unsigned TWtp = TWtpDefault,
  parameter int unsigned TRtp = TRtpDefault,
  parameter int unsigned TCcd = TCcdDefault,
  parameter int unsigned TMrd = TMrdDefault,
  parameter int unsigned TRfc = TRfcDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_ba,
  input  logic [13:0] cmd_addr,
  output logic        cmd_err,
  output logic        init_done,
  output logic        resetbar,
  output logic        cke,
  output logic        csbar,
  output logic        rasbar,
  output logic        casbar,
  output logic        webar,
  output logic [2:0]  ba,
  output logic [13:0] a
);

  init_state_e   state_q, state_d;
  logic [Tw-1:0] cnt_q, cnt_d;
  logic [Tw-1:0] ccd_q, ccd_d;
  logic [Tw-1:0] gap_q, gap_d;
  logic [3:0]    pins_q, pins_d;
  logic [2:0]    ba_q, ba_d;
  logic [13:0]   a_q, a_d;
  logic          err_q, err_d;

  logic [NumBanks-1:0] act_ok, col_ok, pre_ok, is_open;
  logic [NumBanks-1:0] act_iss, pre_iss, rd_iss, wr_iss;
  logic                illegal, timing_ok, fire, issue;
  op_e                 op;

  assign op = op_e'(cmd_op);

  function automatic logic [Tw-1:0] dec(input logic [Tw-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      StRstLow: if (cnt_q == Tw'(TRst - 1)) begin state_d = StCkeLow; cnt_d = '0; end
      StCkeLow: if (cnt_q == Tw'(TCke - 1)) begin state_d = StXpr;    cnt_d = '0; end
      StXpr:    if (cnt_q == Tw'(TXpr - 1)) begin state_d = StRun;    cnt_d = '0; end
      default:  cnt_d = '0;
    endcase
  end

  always_comb begin
    illegal   = 1'b0;
    timing_ok = (gap_q == '0);
    case (op)
      OpAct: begin
        illegal   = is_open[cmd_ba];
        timing_ok = timing_ok & act_ok[cmd_ba];
      end
      OpRd, OpWr: begin
        illegal   = ~is_open[cmd_ba];
        timing_ok = timing_ok & col_ok[cmd_ba] & (ccd_q == '0);
      end
      OpPre: begin
        illegal   = ~is_open[cmd_ba];
        timing_ok = timing_ok & pre_ok[cmd_ba];
      end
      OpPrea:       timing_ok = timing_ok & (&(pre_ok | ~is_open));
      OpRef, OpMrs: illegal = |is_open;
      default: ;
    endcase
    // Illegal commands are swallowed immediately so they never stall the queue.
    cmd_ready = (state_q == StRun) & (~cmd_valid | illegal | timing_ok);
    fire      = cmd_valid & cmd_ready;
    issue     = fire & ~illegal;
  end

  always_comb begin
    act_iss = '0;
    pre_iss = '0;
    rd_iss  = '0;
    wr_iss  = '0;
    for (int i = 0; i < NumBanks; i++) begin
      if (issue && (cmd_ba == 3'(i))) begin
        act_iss[i] = (op == OpAct);
        rd_iss[i]  = (op == OpRd);
        wr_iss[i]  = (op == OpWr);
        pre_iss[i] = (op == OpPre);
      end
      if (issue && (op == OpPrea) && is_open[i]) pre_iss[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NumBanks; g++) begin : g_bank
    ddr3_bank_timer #(
      .Tw   (Tw),
      .TRcd (TRcd),
      .TRp  (TRp),
      .TRas (TRas),
      .TWtp (TWtp),
      .TRtp (TRtp)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .act_issue (act_iss[g]),
      .pre_issue (pre_iss[g]),
      .rd_issue  (rd_iss[g]),
      .wr_issue  (wr_iss[g]),
      .act_ok    (act_ok[g]),
      .col_ok    (col_ok[g]),
      .pre_ok    (pre_ok[g]),
      .is_open   (is_open[g])
    );
  end

  always_comb begin
    pins_d = ((state_d == StXpr) || (state_d == StRun)) ? PinNop : PinDes;
    ba_d   = ba_q;
    a_d    = a_q;
    err_d  = fire & illegal;
    ccd_d  = dec(ccd_q);
    gap_d  = dec(gap_q);
    if (issue) begin
      case (op)
        OpAct: begin pins_d = PinAct; ba_d = cmd_ba; a_d = cmd_addr; end
        OpRd, OpWr: begin
          pins_d = (op == OpRd) ? PinRd : PinWr;
          ba_d   = cmd_ba;
          a_d    = cmd_addr;
          a_d[10] = 1'b0;  // no auto-precharge
          a_d[12] = 1'b1;  // BL8
          ccd_d  = Tw'(TCcd);
        end
        OpPre:  begin pins_d = PinPre; ba_d = cmd_ba; a_d[10] = 1'b0; end
        OpPrea: begin pins_d = PinPre; a_d[10] = 1'b1; end
        OpRef:  begin pins_d = PinRef; gap_d = Tw'(TRfc); end
        OpMrs:  begin pins_d = PinMrs; ba_d = cmd_ba; a_d = cmd_addr; gap_d = Tw'(TMrd); end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRstLow;
      cnt_q   <= '0;
      ccd_q   <= '0;
      gap_q   <= '0;
      pins_q  <= PinDes;
      ba_q    <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ccd_q   <= ccd_d;
      gap_q   <= gap_d;
      pins_q  <= pins_d;
      ba_q    <= ba_d;
      a_q     <= a_d;
      err_q   <= err_d;
    end
  end

  assign resetbar  = (state_q != StRstLow);
  assign cke       = (state_q == StXpr) || (state_q == StRun);
  assign init_done = (state_q == StRun);
  assign {csbar, rasbar, casbar, webar} = pins_q;
  assign ba      = ba_q;
  assign a       = a_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_ddr3_cmd_issuer.sv
// Bench for ddr3_cmd_issuer: deadline-based reference model, a vector table, directed
// timing sequences and randomized traffic.
module tb_ddr3_cmd_issuer;

  localparam int TRcd = 5, TRp = 5, TRas = 14, TWtp = 14, TRtp = 4;
  localparam int TCcd = 4, TMrd = 4, TRfc = 59;
  localparam int RbarAt = 200, CkeAt = 700, DoneAt = 760;
  localparam logic [2:0] ONop = 3'd0, OAct = 3'd1, ORd = 3'd2, OWr = 3'd3;
  localparam logic [2:0] OPre = 3'd4, OPrea = 3'd5, ORef = 3'd6, OMrs = 3'd7;
  localparam logic [3:0] ENop = 4'b0111, EDes = 4'b1111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0, cmd_ba = '0;
  logic [13:0] cmd_addr = '0;
  logic        cmd_ready, cmd_err, init_done, resetbar, cke;
  logic        csbar, rasbar, casbar, webar;
  logic [2:0]  ba;
  logic [13:0] a;

  ddr3_cmd_issuer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ba    (cmd_ba),
    .cmd_addr  (cmd_addr),
    .cmd_err   (cmd_err),
    .init_done (init_done),
    .resetbar  (resetbar),
    .cke       (cke),
    .csbar     (csbar),
    .rasbar    (rasbar),
    .casbar    (casbar),
    .webar     (webar),
    .ba        (ba),
    .a         (a)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  // Reference model: absolute cycle numbers from which each command class may handshake.
  bit open_m[8];
  int nxt_act[8], nxt_col[8], nxt_pre[8];
  int ccd_m, gap_m;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  b;
    logic [13:0] ad;
    logic [3:0]  pins;
    logic        err;
    logic        chk_ba;
    logic [13:0] amask;
    logic [13:0] aval;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      open_m[i] = 0; nxt_act[i] = 0; nxt_col[i] = 0; nxt_pre[i] = 0;
    end
    ccd_m = 0; gap_m = 0; cyc = 0;
  endtask

  task automatic model_eval(input logic v, input logic [2:0] op, input logic [2:0] b,
                            input int c, output logic rdy, output logic ill);
    bit any_open;
    bit ok;
    any_open = 0;
    for (int i = 0; i < 8; i++) any_open |= open_m[i];
    ill = 0;
    ok  = (c >= gap_m);
    case (op)
      OAct: begin ill = open_m[b]; ok &= (c >= nxt_act[b]); end
      ORd, OWr: begin ill = !open_m[b]; ok &= (c >= nxt_col[b]) && (c >= ccd_m); end
      OPre: begin ill = !open_m[b]; ok &= (c >= nxt_pre[b]); end
      OPrea: for (int i = 0; i < 8; i++) if (open_m[i]) ok &= (c >= nxt_pre[i]);
      ORef, OMrs: ill = any_open;
      default: ;
    endcase
    rdy = (c >= DoneAt) && (!v || ill || ok);
  endtask

  // p is the cycle the command appears on the pins.
  task automatic model_update(input logic [2:0] op, input logic [2:0] b, input int p);
    case (op)
      OAct: begin open_m[b] = 1; nxt_col[b] = p + TRcd; nxt_pre[b] = p + TRas; end
      ORd: begin
        if (nxt_pre[b] < p + TRtp) nxt_pre[b] = p + TRtp;
        ccd_m = p + TCcd;
      end
      OWr: begin
        if (nxt_pre[b] < p + TWtp) nxt_pre[b] = p + TWtp;
        ccd_m = p + TCcd;
      end
      OPre: begin open_m[b] = 0; nxt_act[b] = p + TRp; end
      OPrea: for (int i = 0; i < 8; i++)
        if (open_m[i]) begin open_m[i] = 0; nxt_act[i] = p + TRp; end
      ORef: gap_m = p + TRfc;
      OMrs: gap_m = p + TMrd;
      default: ;
    endcase
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [2:0] b,
                      input logic [13:0] ad, output logic fired);
    logic rdy, ill, legal;
    logic [3:0] ep;
    int c;
    c = cyc;
    cmd_valid = v; cmd_op = op; cmd_ba = b; cmd_addr = ad;
    #1;
    model_eval(v, op, b, c, rdy, ill);
    chk("cmd_ready", cmd_ready, rdy);
    fired = v & cmd_ready;
    legal = fired & !ill;
    ep = (c + 1 >= CkeAt) ? ENop : EDes;
    if (legal) begin
      case (op)
        OAct: ep = 4'b0011;
        ORd:  ep = 4'b0101;
        OWr:  ep = 4'b0100;
        OPre, OPrea: ep = 4'b0010;
        ORef: ep = 4'b0001;
        OMrs: ep = 4'b0000;
        default: ;
      endcase
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("pins", {csbar, rasbar, casbar, webar}, ep);
    chk("cmd_err", cmd_err, fired & ill);
    chk("resetbar", resetbar, cyc >= RbarAt);
    chk("cke", cke, cyc >= CkeAt);
    chk("init_done", init_done, cyc >= DoneAt);
    if (legal) begin
      case (op)
        OAct, OMrs: begin chk("ba", ba, b); chk("a", a, ad); end
        ORd, OWr: begin chk("ba", ba, b); chk("a_col", a, (ad & 14'h3BFF) | 14'h1000); end
        OPre: begin chk("ba", ba, b); chk("a10_pre", a[10], 1'b0); end
        OPrea: chk("a10_prea", a[10], 1'b1);
        default: ;
      endcase
      model_update(op, b, c + 1);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] b, input logic [13:0] ad,
                       output int stalls);
    logic f;
    stalls = 0;
    f = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step(1'b1, op, b, ad, f);
      if (f) return;
      stalls++;
    end
    chk("issue_timeout", f, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_resetbar", resetbar, 1'b0);
    chk("rst_cke", cke, 1'b0);
    chk("rst_pins", {csbar, rasbar, casbar, webar}, EDes);
    chk("rst_ba", ba, 3'd0);
    chk("rst_a", a, 14'd0);
    chk("rst_err", cmd_err, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_done", init_done, 1'b0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_init();
    int rb_rise, cke_rise, done_rise;
    logic f;
    rb_rise = -1; cke_rise = -1; done_rise = -1;
    for (int k = 0; k < DoneAt; k++) begin
      step(1'b1, ONop, 3'd0, 14'd0, f);
      if (resetbar && rb_rise < 0) rb_rise = cyc;
      if (cke && cke_rise < 0) cke_rise = cyc;
      if (init_done && done_rise < 0) done_rise = cyc;
    end
    chk("resetbar_rise", rb_rise, RbarAt);
    chk("cke_rise", cke_rise, CkeAt);
    chk("init_done_rise", done_rise, DoneAt);
  endtask

  initial begin
    int s, ca, cw, cp;
    logic f;

    tbl[0]  = '{OAct,  3'd2, 14'h01A5, 4'b0011, 1'b0, 1'b1, 14'h3FFF, 14'h01A5};
    tbl[1]  = '{ORd,   3'd2, 14'h0008, 4'b0101, 1'b0, 1'b1, 14'h3FFF, 14'h1008};
    tbl[2]  = '{OWr,   3'd2, 14'h07FF, 4'b0100, 1'b0, 1'b1, 14'h3FFF, 14'h13FF};
    tbl[3]  = '{OPre,  3'd2, 14'h0400, 4'b0010, 1'b0, 1'b1, 14'h0400, 14'h0000};
    tbl[4]  = '{ORd,   3'd2, 14'h0010, ENop,    1'b1, 1'b0, 14'h0000, 14'h0000};
    tbl[5]  = '{OMrs,  3'd3, 14'h0123, 4'b0000, 1'b0, 1'b1, 14'h3FFF, 14'h0123};
    tbl[6]  = '{ORef,  3'd0, 14'h0000, 4'b0001, 1'b0, 1'b0, 14'h0000, 14'h0000};
    tbl[7]  = '{OAct,  3'd3, 14'h0055, 4'b0011, 1'b0, 1'b1, 14'h3FFF, 14'h0055};
    tbl[8]  = '{ORef,  3'd0, 14'h0000, ENop,    1'b1, 1'b0, 14'h0000, 14'h0000};
    tbl[9]  = '{OMrs,  3'd1, 14'h0001, ENop,    1'b1, 1'b0, 14'h0000, 14'h0000};
    tbl[10] = '{OAct,  3'd3, 14'h0077, ENop,    1'b1, 1'b0, 14'h0000, 14'h0000};
    tbl[11] = '{OPrea, 3'd0, 14'h0000, 4'b0010, 1'b0, 1'b0, 14'h0400, 14'h0400};
    tbl[12] = '{ONop,  3'd0, 14'h0000, ENop,    1'b0, 1'b0, 14'h0000, 14'h0000};
    tbl[13] = '{OWr,   3'd3, 14'h0020, ENop,    1'b1, 1'b0, 14'h0000, 14'h0000};

    #1;
    do_reset();
    run_init();

    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].op, tbl[i].b, tbl[i].ad, s);
      chk($sformatf("tbl%0d_pins", i), {csbar, rasbar, casbar, webar}, tbl[i].pins);
      chk($sformatf("tbl%0d_err", i), cmd_err, tbl[i].err);
      if (tbl[i].chk_ba) chk($sformatf("tbl%0d_ba", i), ba, tbl[i].b);
      if (tbl[i].amask != 14'd0) chk($sformatf("tbl%0d_a", i), a & tbl[i].amask, tbl[i].aval);
    end

    // ACT -> RD same bank waits tRCD
    issue(OAct, 3'd2, 14'h01A5, s);
    issue(ORd, 3'd2, 14'h0008, s);
    chk("trcd_stall", s, TRcd);
    chk("rd_pins", {csbar, rasbar, casbar, webar}, 4'b0101);
    chk("rd_ba", ba, 3'd2);
    chk("rd_a", a, 14'h1008);
    issue(OPre, 3'd2, 14'h0000, s);

    // PRE waits for both tRAS and write recovery, then ACT waits tRP
    issue(OAct, 3'd0, 14'h0100, s); ca = cyc - 1;
    issue(OWr, 3'd0, 14'h0040, s);  cw = cyc - 1;
    issue(OPre, 3'd0, 14'h0000, s); cp = cyc - 1;
    chk("pre_after_wr", cp, ((ca + 1 + TRas) > (cw + 1 + TWtp)) ? ca + 1 + TRas : cw + 1 + TWtp);
    issue(OAct, 3'd0, 14'h0101, s);
    chk("trp_stall", s, TRp);
    issue(OPre, 3'd0, 14'h0000, s);

    // Column command to a closed bank is dropped with an error pulse
    issue(ORd, 3'd1, 14'h0008, s);
    chk("rd_closed_stall", s, 0);
    chk("rd_closed_err", cmd_err, 1'b1);
    chk("rd_closed_pins", {csbar, rasbar, casbar, webar}, ENop);
    step(1'b0, ONop, 3'd0, 14'd0, f);
    chk("err_one_cycle", cmd_err, 1'b0);
    issue(OAct, 3'd1, 14'h0002, s);
    chk("b1_still_closed", cmd_err, 1'b0);
    issue(OPre, 3'd1, 14'h0000, s);

    // Refresh blocks the next command for tRFC; refresh with an open bank is illegal
    issue(OPrea, 3'd0, 14'h0000, s);
    issue(ORef, 3'd0, 14'h0000, s);
    issue(OAct, 3'd4, 14'h0004, s);
    chk("trfc_stall", s, TRfc);
    issue(OPre, 3'd4, 14'h0000, s);
    issue(OAct, 3'd3, 14'h0003, s);
    issue(ORef, 3'd0, 14'h0000, s);
    chk("ref_open_err", cmd_err, 1'b1);
    chk("ref_open_pins", {csbar, rasbar, casbar, webar}, ENop);

    // Reset in the middle of a tRCD stall
    issue(OAct, 3'd5, 14'h0005, s);
    step(1'b1, ORd, 3'd5, 14'h0008, f);
    chk("rcd_hold", f, 1'b0);
    do_reset();
    run_init();
    issue(ORd, 3'd5, 14'h0008, s);
    chk("bank_closed_after_reset", cmd_err, 1'b1);

    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [2:0] op;
      r = $urandom_range(0, 99);
      if (r < 30) op = OAct;
      else if (r < 50) op = ORd;
      else if (r < 65) op = OWr;
      else if (r < 80) op = OPre;
      else if (r < 85) op = OPrea;
      else if (r < 88) op = ORef;
      else if (r < 92) op = OMrs;
      else op = ONop;
      step($urandom_range(0, 9) < 8, op, 3'($urandom_range(0, 3)),
           14'($urandom_range(0, 16383)), f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
